// File: rtl/snake_game_pkg.sv
// Shared game-state definitions for the sequencer and the colour stage.
// The M_STATE encoding here is the contract with the VGA colour path.
package snake_game_pkg;

    // Width of the M_STATE bus
    localparam int unsigned STATE_W   = 2;
    // Width of the SCORE bus
    localparam int unsigned SCORE_W   = 8;
    // Width of the WIN-animation frame counter
    localparam int unsigned WIN_CNT_W = 16;

    // Code 2'b11 is deliberately left unnamed; the sequencer treats it as illegal
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10
    } game_state_e;

endpackage

// File: rtl/btn_edge_detect.sv
// Button conditioner: two-flop synchroniser for an asynchronous raw button,
// followed by a registered rising-edge strobe. The strobe is high for one
// cycle, three clocks after the raw rise; a held button yields a single strobe.
module btn_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_edge
);

    // r_sync[0], r_sync[1] form the synchroniser; r_sync[2] is the previous level
    logic [2:0] r_sync;
    logic       r_edge;
    logic       w_rise;

    // Rising edge of the synchronised level
    assign w_rise = r_sync[1] & ~r_sync[2];

    // Synchroniser chain and registered edge strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], i_btn};
            r_edge <= w_rise;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/game_state_sequencer.sv
// Master game-state controller for the snake game.
// Sequences IDLE -> PLAY -> WIN/IDLE from button, score and collision events,
// drives the M_STATE bus to the colour stage, and issues GAME_RST / GAME_RUN to
// the snake and target logic. All outputs are registered: an event strobe
// sampled on one clock is visible on the outputs after that clock.
// Optional feature: define PAUSE_EN to add a pause toggle on BTN_PAUSE.
module game_state_sequencer
    import snake_game_pkg::*;
#(
    parameter int unsigned TARGET_SCORE = 10,
    parameter int unsigned WIN_FRAMES   = 600
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTN_START,
    input  logic               BTN_PAUSE,
    input  logic               FRAME_TICK,
    input  logic               TARGET_HIT,
    input  logic               SNAKE_DEAD,
    output logic [STATE_W-1:0] M_STATE,
    output logic [SCORE_W-1:0] SCORE,
    output logic               GAME_RST,
    output logic               GAME_RUN
);

    localparam logic [SCORE_W-1:0]   LP_TARGET   = SCORE_W'(TARGET_SCORE);
    localparam logic [WIN_CNT_W-1:0] LP_WIN_LAST = WIN_CNT_W'(WIN_FRAMES - 1);

    // Registered state and outputs
    game_state_e          r_state;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_game_rst;
    logic                 r_game_run;
    logic [WIN_CNT_W-1:0] r_win_cnt;

    // Next-state values
    game_state_e          w_state_next;
    logic [SCORE_W-1:0]   w_score_next;
    logic                 w_game_rst_next;
    logic                 w_game_run_next;
    logic [WIN_CNT_W-1:0] w_win_cnt_next;

    logic                 w_start_edge;
    logic [SCORE_W-1:0]   w_score_inc;
    // High when PLAY events (hit/death) are being acted on
    logic                 w_play_active;
    // Pause level the outputs will reflect after this clock
    logic                 w_pause_next;

    btn_edge_detect u_start_edge (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_btn  (BTN_START),
        .o_edge (w_start_edge)
    );

`ifdef PAUSE_EN
    logic r_pause;
    logic w_pause_edge;

    btn_edge_detect u_pause_edge (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_btn  (BTN_PAUSE),
        .o_edge (w_pause_edge)
    );

    assign w_play_active = ~r_pause;

    // Pause toggles only in PLAY and is dropped on any exit from PLAY
    always_comb begin
        w_pause_next = r_pause;
        if (r_state == ST_PLAY && w_pause_edge) begin
            w_pause_next = ~r_pause;
        end
        if (w_state_next != ST_PLAY) begin
            w_pause_next = 1'b0;
        end
    end

    // Pause flag register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pause <= 1'b0;
        end else begin
            r_pause <= w_pause_next;
        end
    end
`else
    // No pause hardware: the button is intentionally left unconnected
    logic w_unused_btn_pause;
    assign w_unused_btn_pause = BTN_PAUSE;
    assign w_play_active      = 1'b1;
    assign w_pause_next       = 1'b0;
`endif

    assign w_score_inc = r_score + 1'b1;

    // Next-state and registered-output logic for the game FSM
    always_comb begin
        w_state_next    = r_state;
        w_score_next    = r_score;
        w_game_rst_next = 1'b0;
        w_win_cnt_next  = r_win_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_next    = ST_PLAY;
                    w_score_next    = '0;
                    w_game_rst_next = 1'b1;
                end
            end

            ST_PLAY: begin
                // Death outranks a same-cycle hit so the displayed score is final
                if (w_play_active) begin
                    if (SNAKE_DEAD) begin
                        w_state_next = ST_IDLE;
                    end else if (TARGET_HIT) begin
                        w_score_next = w_score_inc;
                        if (w_score_inc == LP_TARGET) begin
                            w_state_next   = ST_WIN;
                            w_win_cnt_next = '0;
                        end
                    end
                end
            end

            ST_WIN: begin
                // A restart request beats the animation timeout
                if (w_start_edge) begin
                    w_state_next    = ST_PLAY;
                    w_score_next    = '0;
                    w_game_rst_next = 1'b1;
                end else if (FRAME_TICK) begin
                    if (r_win_cnt == LP_WIN_LAST) begin
                        w_state_next   = ST_IDLE;
                        w_win_cnt_next = '0;
                    end else begin
                        w_win_cnt_next = r_win_cnt + 1'b1;
                    end
                end
            end

            default: begin
                // Illegal code 2'b11: fall back to the start screen
                w_state_next   = ST_IDLE;
                w_win_cnt_next = '0;
            end
        endcase

        w_game_run_next = (w_state_next == ST_PLAY) && !w_pause_next;
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_score    <= '0;
            r_game_rst <= 1'b0;
            r_game_run <= 1'b0;
            r_win_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_score    <= w_score_next;
            r_game_rst <= w_game_rst_next;
            r_game_run <= w_game_run_next;
            r_win_cnt  <= w_win_cnt_next;
        end
    end

    assign M_STATE  = r_state;
    assign SCORE    = r_score;
    assign GAME_RST = r_game_rst;
    assign GAME_RUN = r_game_run;

endmodule
